page_walker: RTL
================

// Module: page_walker
// PURPOSE
//  Sv39 hardware page-table walker. On a TLB miss it fetches PTEs level by
//  level (L2 -> L1 -> L0) through a single memory read port. It then returns
//  either a leaf translation or a fault.
//  Sits directly upstream of the TLB: a successful walk drives the TLB
//  replace / replace_va / page_walk_rsp inputs for one cycle.
// PARAMETERS
//  ISIDE    0  1 = instance serves the fetch-side TLB (copied to mem_req_iside)
//  SVNAPOT  1  1 = L0 leaf with N=1 and ppn[3:0]==4'b1000 reports pgsize 3 (64K)
// PORTS
//  clk             in   1   clock
//  reset           in   1   asynchronous, active-low reset
//  clear           in   1   abort / flush (satp write, sfence)
//  satp_ppn        in   44  root page-table PPN, sampled at request accept
//  req_valid       in   1   walk request
//  req_ready       out  1   high only in IDLE
//  req_va          in   64  virtual address to translate
//  mem_req_valid   out  1   PTE read request, held until mem_req_ack
//  mem_req_ack     in   1   memory accepted request
//  mem_req_addr    out  64  8-byte-aligned PTE address
//  mem_req_iside   out  1   = ISIDE
//  mem_rsp_valid   in   1   PTE data valid (one cycle)
//  mem_rsp_data    in   64  PTE
//  replace         out  1   1-cycle pulse: successful walk, TLB must install entry
//  replace_va      out  64  VA of the completed walk (valid with replace/fault)
//  page_walk_rsp   out  struct  {paddr[63:0], pgsize[1:0], dirty, readable,
//                               writable, executable, user}
//  fault           out  1   1-cycle pulse: walk ended in page fault
//  busy            out  1   state != IDLE
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE. All outputs 0 except req_ready=1.
//  FSM: IDLE -> REQ -> WAIT -> (REQ next level | DONE | FAULT) -> IDLE.
//   - IDLE: on req_valid latch va and satp_ppn, set level=2.
//     If va[63:39] != {25{va[38]}}, go to FAULT without any memory access.
//   - REQ: mem_req_valid=1, addr={8'b0, base_ppn, va_vpn[level], 3'b000}.
//     L2 base = satp_ppn; lower levels use the PPN of the previous PTE.
//     Go to WAIT in the cycle mem_req_ack is high.
//   - WAIT: on mem_rsp_valid decode the PTE.
//     PTE bits: V0 R1 W2 X3 U4 A6 D7, PPN[53:10], N63.
//     * !V or (W & !R): FAULT.
//     * R|X (leaf):
//       - FAULT if !A (no hardware A/D update).
//       - FAULT if level 2 and ppn[17:0]!=0, or level 1 and ppn[8:0]!=0.
//       - Otherwise go to DONE.
//     * Non-leaf at level 0: FAULT. Otherwise level--, go to REQ.
//  DONE: replace=1 for exactly one cycle. Outputs:
//   - pgsize = 2-level (L2->0 1G, L1->1 2M, L0->2 4K), or 3 per SVNAPOT.
//   - paddr = {8'b0, ppn, 12'b0}.
//   - permission bits copied from the PTE.
//  FAULT: fault=1 for exactly one cycle; replace stays 0.
//  page_walk_rsp and replace_va hold their values until the next walk completes.
//  Latency: accept -> replace is 1 + sum over levels of (ack wait + rsp wait + 1)
//  cycles; with zero-wait memory, a 4K walk takes 10 cycles.
//  clear:
//   - In IDLE or REQ before ack: return to IDLE next cycle.
//   - In WAIT: enter DRAIN, swallow the outstanding mem_rsp_valid, then go IDLE.
//   - clear never produces replace or fault.
//  clear and req_valid in the same IDLE cycle: clear wins, request not accepted.
//  Exactly one memory request is outstanding at a time.
//  mem_rsp_valid outside WAIT/DRAIN is ignored.
// TESTING
//  1. 4K walk, satp_ppn=0x80000, va=0x0000_0040_1234_5678 (non-canonical):
//     fault pulse, no mem_req.
//  2. va=0x1234_5000; L2/L1 PTEs non-leaf, L0 PTE=0x2000_04CF (ppn 0x80001):
//     three reads, replace=1, paddr=0x8000_1000, pgsize=2, RWX and A set,
//     D=1, U=0.
//  3. L1 leaf PTE with ppn=0x80200: pgsize=1, paddr=0x8020_0000.
//     Same with ppn=0x80201: fault, replace=0.
//  4. L0 PTE with V=0, or W=1/R=0, or A=0: fault pulse after 3rd read.
//     L0 non-leaf: fault.
//  5. clear asserted in WAIT with rsp 4 cycles later: no replace or fault,
//     busy drops the cycle after that rsp, next request walks normally.
//  6. Assert reset mid-walk with mem_req_valid high: all outputs 0
//     asynchronously, req_ready=1 after release.

Source files
------------

// File: rtl/page_walker.sv
// Sv39 page-table walker: walks L2 -> L1 -> L0 through one PTE read port and reports a leaf or a fault.
// Latency: 1 + per level (ack wait + rsp wait + 1 decode) cycles; a zero-wait 4K walk takes 10 cycles.
// Backpressure: mem_req_valid held until mem_req_ack, one read outstanding; req_ready only while IDLE.
module page_walker #(
  parameter bit ISIDE   = 1'b0,
  parameter bit SVNAPOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [43:0] satp_ppn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_va,
  output logic        mem_req_valid,
  input  logic        mem_req_ack,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_iside,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic        replace,
  output logic [63:0] replace_va,
  // {paddr[63:0], pgsize[1:0], dirty, readable, writable, executable, user}
  output logic [70:0] page_walk_rsp,
  output logic        fault,
  output logic        busy
);

  // DECODE inspects the registered PTE one cycle after it arrives.
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DECODE, DONE, FAULT, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [63:0] va_q;
  logic [43:0] base_q;
  logic [1:0]  level_q;
  logic [63:0] pte_q;
  logic [63:0] va_out_q;
  logic [70:0] rsp_q;

  logic        va_canonical;
  logic [8:0]  vpn;
  logic [43:0] pte_ppn;
  logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d, pte_n;
  logic        misaligned;
  logic        napot;
  logic [1:0]  pgsize;
  logic [70:0] rsp_nxt;
  logic        unused_pte;

  assign va_canonical = (req_va[63:39] == {25{req_va[38]}});

  assign pte_v   = pte_q[0];
  assign pte_r   = pte_q[1];
  assign pte_w   = pte_q[2];
  assign pte_x   = pte_q[3];
  assign pte_u   = pte_q[4];
  assign pte_a   = pte_q[6];
  assign pte_d   = pte_q[7];
  assign pte_n   = pte_q[63];
  assign pte_ppn = pte_q[53:10];
  assign unused_pte = ^{pte_q[62:54], pte_q[9:8], pte_q[5]};

  // Superpage leaves must have the PPN bits below their page size clear.
  assign misaligned = ((level_q == 2'd2) && (pte_ppn[17:0] != 18'd0)) ||
                      ((level_q == 2'd1) && (pte_ppn[8:0] != 9'd0));
  assign napot   = SVNAPOT && (level_q == 2'd0) && pte_n && (pte_ppn[3:0] == 4'b1000);
  assign pgsize  = napot ? 2'd3 : (2'd2 - level_q);
  assign rsp_nxt = {8'b0, pte_ppn, 12'b0, pgsize, pte_d, pte_r, pte_w, pte_x, pte_u};

  // Select the VPN slice that indexes the table at the current level.
  always_comb begin
    vpn = va_q[20:12];
    case (level_q)
      2'd2:    vpn = va_q[38:30];
      2'd1:    vpn = va_q[29:21];
      default: vpn = va_q[20:12];
    endcase
  end

  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = {8'b0, base_q, vpn, 3'b000};
  assign mem_req_iside = ISIDE;
  assign replace       = (state == DONE);
  assign fault         = (state == FAULT);
  assign replace_va    = va_out_q;
  assign page_walk_rsp = rsp_q;

  // Next-state: walk sequencing, PTE decode and abort handling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!clear && req_valid) state_nxt = va_canonical ? REQ : FAULT;
      end
      REQ: begin
        if (mem_req_ack)  state_nxt = clear ? DRAIN : WAIT;
        else if (clear)   state_nxt = IDLE;
      end
      WAIT: begin
        // A response arriving together with clear is already consumed.
        if (clear)              state_nxt = mem_rsp_valid ? IDLE : DRAIN;
        else if (mem_rsp_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (clear)                          state_nxt = IDLE;
        else if (!pte_v || (pte_w && !pte_r)) state_nxt = FAULT;
        else if (pte_r || pte_x)            state_nxt = (!pte_a || misaligned) ? FAULT : DONE;
        else if (level_q == 2'd0)           state_nxt = FAULT;
        else                                state_nxt = REQ;
      end
      DONE:    state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      DRAIN: begin
        if (mem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Walk context: latched VA, current table base, level and fetched PTE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      va_q    <= '0;
      base_q  <= '0;
      level_q <= '0;
      pte_q   <= '0;
    end else begin
      if (state == IDLE && state_nxt != IDLE) begin
        va_q    <= req_va;
        base_q  <= satp_ppn;
        level_q <= 2'd2;
      end
      if (state == WAIT && mem_rsp_valid && !clear) pte_q <= mem_rsp_data;
      if (state == DECODE && state_nxt == REQ) begin
        base_q  <= pte_ppn;
        level_q <= level_q - 2'd1;
      end
    end
  end

  // Completion results; held until the next walk finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_q    <= '0;
      va_out_q <= '0;
    end else if (state_nxt == DONE) begin
      rsp_q    <= rsp_nxt;
      va_out_q <= va_q;
    end else if (state_nxt == FAULT) begin
      va_out_q <= (state == IDLE) ? req_va : va_q;
    end
  end

endmodule
